// File: rtl/ball_game_ctrl.sv
// rtl/ball_game_ctrl.sv - ball game sequencer: ball motion, paddle, bounces, score and lives
module ball_game_ctrl #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int BALL_SIZE   = 8,
    parameter int PADDLE_W    = 64,
    parameter int PADDLE_Y    = 460,
    parameter int PADDLE_STEP = 8,
    parameter int SPEED       = 2,
    parameter int LIVES       = 3
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        rotary_event,
    input  logic        rotary_right,
    input  logic        serve,
    output logic [10:0] ball_x,
    output logic [10:0] ball_y,
    output logic [10:0] paddle_x,
    output logic [15:0] score,
    output logic [1:0]  lives,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PLAY = 3'd1,
        MISS = 3'd2,
        OVER = 3'd3
    } state_t;

    localparam logic signed [11:0] SPD     = 12'(SPEED);
    localparam logic signed [11:0] X_MAX   = 12'(H_ACTIVE - BALL_SIZE);
    localparam logic signed [11:0] Y_MAX   = 12'(V_ACTIVE - BALL_SIZE);
    localparam logic signed [11:0] HIT_TOP = 12'(PADDLE_Y - BALL_SIZE);
    localparam logic signed [11:0] PAD_Y   = 12'(PADDLE_Y);
    localparam logic signed [11:0] BSZ     = 12'(BALL_SIZE);
    localparam logic signed [11:0] PW      = 12'(PADDLE_W);
    localparam logic signed [11:0] STEP    = 12'(PADDLE_STEP);
    localparam logic signed [11:0] PAD_MAX = 12'(H_ACTIVE - PADDLE_W);
    localparam logic [10:0] PAD_HOME   = 11'((H_ACTIVE - PADDLE_W) / 2);
    localparam logic [10:0] DOCK_OFS   = 11'(PADDLE_W / 2 - BALL_SIZE / 2);
    localparam logic [10:0] DOCK_Y     = 11'(PADDLE_Y - BALL_SIZE);
    localparam logic [1:0]  LIVES_INIT = 2'(LIVES);

    state_t state_q;
    logic   dx_pos, dy_pos;

    logic signed [11:0] nx, ny, new_x, new_y, pad, pstep, pad_next;
    logic               dx_next, dy_next, hit, miss;

    assign state = state_q;

    // Next ball position for a frame tick; the collision uses the current (pre-move) paddle.
    always_comb begin
        nx      = $signed({1'b0, ball_x}) + (dx_pos ? SPD : -SPD);
        ny      = $signed({1'b0, ball_y}) + (dy_pos ? SPD : -SPD);
        pad     = $signed({1'b0, paddle_x});
        new_x   = nx;
        dx_next = dx_pos;
        if (nx <= 12'sd0) begin
            new_x   = 12'sd0;
            dx_next = 1'b1;
        end else if (nx >= X_MAX) begin
            new_x   = X_MAX;
            dx_next = 1'b0;
        end
        new_y   = ny;
        dy_next = dy_pos;
        hit     = 1'b0;
        miss    = 1'b0;
        if (ny <= 12'sd0) begin
            new_y   = 12'sd0;
            dy_next = 1'b1;
        end else if (dy_pos && ny >= HIT_TOP && ny < PAD_Y &&
                     (new_x + BSZ) > pad && new_x < (pad + PW)) begin
            new_y   = HIT_TOP;
            dy_next = 1'b0;
            hit     = 1'b1;
        end else if (ny >= Y_MAX) begin
            new_y = Y_MAX;
            miss  = 1'b1;
        end
        pstep    = pad + (rotary_right ? STEP : -STEP);
        pad_next = pstep;
        if (pstep < 12'sd0) begin
            pad_next = 12'sd0;
        end else if (pstep > PAD_MAX) begin
            pad_next = PAD_MAX;
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_q  <= IDLE;
            paddle_x <= PAD_HOME;
            ball_x   <= PAD_HOME + DOCK_OFS;
            ball_y   <= DOCK_Y;
            score    <= 16'd0;
            lives    <= LIVES_INIT;
            dx_pos   <= 1'b1;
            dy_pos   <= 1'b0;
        end else begin
            if (rotary_event && state_q != OVER) begin
                paddle_x <= pad_next[10:0];
            end
            case (state_q)
                IDLE: begin
                    ball_x <= paddle_x + DOCK_OFS;
                    ball_y <= DOCK_Y;
                    if (serve) begin
                        state_q <= PLAY;
                        dx_pos  <= 1'b1;
                        dy_pos  <= 1'b0;
                    end
                end
                PLAY: begin
                    if (frame_tick) begin
                        ball_x <= new_x[10:0];
                        ball_y <= new_y[10:0];
                        dx_pos <= dx_next;
                        dy_pos <= dy_next;
                        if (hit) begin
                            score <= score + 16'd1;
                        end
                        if (miss) begin
                            state_q <= MISS;
                        end
                    end
                end
                MISS: begin
                    lives   <= lives - 2'd1;
                    state_q <= (lives == 2'd1) ? OVER : IDLE;
                end
                OVER: begin
                    if (serve) begin
                        state_q  <= IDLE;
                        score    <= 16'd0;
                        lives    <= LIVES_INIT;
                        paddle_x <= PAD_HOME;
                        ball_x   <= PAD_HOME + DOCK_OFS;
                        ball_y   <= DOCK_Y;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ball_game_ctrl.sv
// tb/tb_ball_game_ctrl.sv - directed and randomized checks of ball_game_ctrl against a game model
module tb_ball_game_ctrl;

    logic        CLK = 1'b0;
    logic        reset, frame_tick, rotary_event, rotary_right, serve;
    logic [10:0] ball_x, ball_y, paddle_x;
    logic [15:0] score;
    logic [1:0]  lives;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;

    int m_px, m_bx, m_by, m_dx, m_dy, m_sc, m_lv, m_st;

    ball_game_ctrl dut (
        .CLK(CLK), .reset(reset), .frame_tick(frame_tick),
        .rotary_event(rotary_event), .rotary_right(rotary_right), .serve(serve),
        .ball_x(ball_x), .ball_y(ball_y), .paddle_x(paddle_x),
        .score(score), .lives(lives), .state(state)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Game rules applied to the model for one clock edge with the given inputs.
    task automatic model_edge(input bit rs_n, input bit fr, input bit rot, input bit rr, input bit sv);
        int px_n, bx_n, by_n, dx_n, dy_n, sc_n, lv_n, st_n, nx, ny;
        if (!rs_n) begin
            m_px = 288; m_bx = 316; m_by = 452; m_sc = 0; m_lv = 3; m_st = 0; m_dx = 2; m_dy = -2;
            return;
        end
        px_n = m_px; bx_n = m_bx; by_n = m_by; dx_n = m_dx; dy_n = m_dy;
        sc_n = m_sc; lv_n = m_lv; st_n = m_st;
        if (rot && m_st != 3) begin
            px_n = m_px + (rr ? 8 : -8);
            if (px_n < 0) px_n = 0;
            if (px_n > 576) px_n = 576;
        end
        case (m_st)
            0: begin
                bx_n = m_px + 28;
                by_n = 452;
                if (sv) begin st_n = 1; dx_n = 2; dy_n = -2; end
            end
            1: if (fr) begin
                nx = m_bx + m_dx;
                ny = m_by + m_dy;
                if (nx <= 0) begin bx_n = 0; dx_n = 2; end
                else if (nx >= 632) begin bx_n = 632; dx_n = -2; end
                else bx_n = nx;
                if (ny <= 0) begin by_n = 0; dy_n = 2; end
                else if (m_dy > 0 && ny >= 452 && ny < 460 && bx_n + 8 > m_px && bx_n < m_px + 64) begin
                    by_n = 452; dy_n = -2; sc_n = (m_sc + 1) % 65536;
                end
                else if (ny >= 472) begin by_n = 472; st_n = 2; end
                else by_n = ny;
            end
            2: begin
                lv_n = m_lv - 1;
                st_n = (lv_n == 0) ? 3 : 0;
            end
            3: if (sv) begin
                st_n = 0; sc_n = 0; lv_n = 3; px_n = 288; bx_n = 316; by_n = 452;
            end
            default: ;
        endcase
        m_px = px_n; m_bx = bx_n; m_by = by_n; m_dx = dx_n; m_dy = dy_n;
        m_sc = sc_n; m_lv = lv_n; m_st = st_n;
    endtask

    task automatic step(input bit rs_n, input bit fr, input bit rot, input bit rr, input bit sv);
        reset = rs_n; frame_tick = fr; rotary_event = rot; rotary_right = rr; serve = sv;
        @(posedge CLK);
        model_edge(rs_n, fr, rot, rr, sv);
        #1;
        chk("model.paddle_x", 32'(paddle_x), 32'(m_px));
        chk("model.ball_x",   32'(ball_x),   32'(m_bx));
        chk("model.ball_y",   32'(ball_y),   32'(m_by));
        chk("model.score",    32'(score),    32'(m_sc));
        chk("model.lives",    32'(lives),    32'(m_lv));
        chk("model.state",    32'(state),    32'(m_st));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1, 1, 0, 0, 0);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b0; frame_tick = 1'b0; rotary_event = 1'b0; rotary_right = 1'b0; serve = 1'b0;
        m_px = 0; m_bx = 0; m_by = 0; m_dx = 0; m_dy = 0; m_sc = 0; m_lv = 0; m_st = 0;

        do_reset();
        chk("rst.paddle_x", 32'(paddle_x), 288);
        chk("rst.ball_x", 32'(ball_x), 316);
        chk("rst.ball_y", 32'(ball_y), 452);
        chk("rst.score", 32'(score), 0);
        chk("rst.lives", 32'(lives), 3);
        chk("rst.state", 32'(state), 0);
        step(1, 0, 0, 0, 1);
        chk("rel_serve.state", 32'(state), 1);

        do_reset();
        for (int i = 0; i < 40; i++) step(1, 0, 1, 1, 0);
        step(1, 0, 0, 0, 0);
        chk("clamp_r.paddle_x", 32'(paddle_x), 576);
        chk("clamp_r.ball_x", 32'(ball_x), 604);
        for (int i = 0; i < 80; i++) step(1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("clamp_l.paddle_x", 32'(paddle_x), 0);
        chk("clamp_l.ball_x", 32'(ball_x), 28);

        do_reset();
        step(1, 0, 0, 0, 1);
        ticks(1);
        chk("t1.ball_x", 32'(ball_x), 318);
        chk("t1.ball_y", 32'(ball_y), 450);
        chk("t1.state", 32'(state), 1);
        ticks(157);
        chk("t158.ball_x", 32'(ball_x), 632);
        ticks(1);
        chk("t159.ball_x", 32'(ball_x), 630);
        ticks(67);
        chk("t226.ball_y", 32'(ball_y), 0);
        ticks(1);
        chk("t227.ball_y", 32'(ball_y), 2);
        ticks(173);
        for (int i = 0; i < 36; i++) step(1, 0, 1, 0, 0);
        chk("left36.paddle_x", 32'(paddle_x), 0);
        ticks(52);
        chk("hit.ball_x", 32'(ball_x), 44);
        chk("hit.ball_y", 32'(ball_y), 452);
        chk("hit.score", 32'(score), 1);
        ticks(1);
        chk("hit_up.ball_y", 32'(ball_y), 450);

        do_reset();
        step(1, 0, 0, 0, 1);
        ticks(461);
        chk("t461.state", 32'(state), 1);
        ticks(1);
        chk("miss.ball_y", 32'(ball_y), 472);
        chk("miss.state", 32'(state), 2);
        step(1, 0, 0, 0, 0);
        chk("miss_idle.state", 32'(state), 0);
        chk("miss_idle.lives", 32'(lives), 2);
        step(1, 0, 0, 0, 0);
        chk("redock.ball_x", 32'(ball_x), 316);
        chk("redock.ball_y", 32'(ball_y), 452);

        for (int k = 0; k < 2; k++) begin
            step(1, 0, 0, 0, 1);
            ticks(462);
            step(1, 0, 0, 0, 0);
        end
        chk("over.state", 32'(state), 3);
        chk("over.lives", 32'(lives), 0);
        step(1, 0, 1, 1, 0);
        chk("over.paddle_frozen", 32'(paddle_x), 288);
        ticks(3);
        chk("over.ball_held_x", 32'(ball_x), 24);
        chk("over.ball_held_y", 32'(ball_y), 472);
        step(1, 0, 0, 0, 1);
        chk("restart.state", 32'(state), 0);
        chk("restart.lives", 32'(lives), 3);
        chk("restart.score", 32'(score), 0);
        chk("restart.ball_x", 32'(ball_x), 316);

        do_reset();
        step(1, 0, 0, 0, 1);
        for (int i = 0; i < 30; i++) step(1, 0, 1, 0, 0);
        ticks(451);
        step(1, 1, 1, 1, 0);
        chk("coinc.score", 32'(score), 1);
        chk("coinc.paddle_x", 32'(paddle_x), 56);
        chk("coinc.ball_y", 32'(ball_y), 452);

        do_reset();
        for (int i = 0; i < 20000; i++) begin
            step(($urandom_range(0, 5000) != 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 150) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ball_game_ctrl.md
Name: ball_game_ctrl

Overview:
- Game-sequencing controller for the VGA ball game: owns the ball and paddle positions, wall and paddle bounce, score, and lives.
- Runs on the 50 MHz system clock. Advances the ball once per video frame on a one-cycle frame_tick pulse, which comes from the VGA timing block's vertical-sync edge and is resynchronised upstream.
- Moves the paddle on rotary-encoder events from the rotation-direction decoder.
- Feeds ball_x, ball_y and paddle_x to the drawing block.

Parameters:
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines per frame
BALL_SIZE, 8, ball square edge in pixels
PADDLE_W, 64, paddle width in pixels
PADDLE_Y, 460, top line of paddle
PADDLE_STEP, 8, pixels moved per rotary event
SPEED, 2, ball pixels per frame per axis
LIVES, 3, lives per game

Ports:
CLK  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-low reset
frame_tick  in  1  one-cycle pulse per frame
rotary_event  in  1  one-cycle pulse per encoder detent
rotary_right  in  1  direction qualifier for rotary_event (1 = right)
serve  in  1  one-cycle pulse; launches ball or restarts game
ball_x  out  11  ball left edge
ball_y  out  11  ball top edge
paddle_x  out  11  paddle left edge
score  out  16  paddle hits this game, wraps at 65535 -> 0
lives  out  2  remaining lives
state  out  3  0 = IDLE, 1 = PLAY, 2 = MISS, 3 = OVER

Behaviour:
- Reset (reset = 0 at a clock edge) sets:
  - paddle_x = (H_ACTIVE-PADDLE_W)/2 = 288
  - ball_x = 316, ball_y = 452
  - score = 0, lives = LIVES
  - state = IDLE, dx = +SPEED, dy = -SPEED
- Reset has priority over all other inputs in every state.
- Docking:
  - Ball "docked" means ball_x = paddle_x + PADDLE_W/2 - BALL_SIZE/2 and ball_y = PADDLE_Y - BALL_SIZE.
  - In IDLE the ball is re-docked every cycle from the current paddle_x register, so it lags a paddle move by one cycle.
- Paddle:
  - On rotary_event, paddle_x += PADDLE_STEP if rotary_right, else -= PADDLE_STEP.
  - Result is clamped to [0, H_ACTIVE-PADDLE_W] = [0, 576].
  - Paddle is frozen in OVER.
- IDLE:
  - serve -> PLAY, with dx = +SPEED, dy = -SPEED.
  - frame_tick is ignored.
- PLAY, on frame_tick (use 12-bit signed intermediates nx = ball_x+dx, ny = ball_y+dy):
  - X axis: if nx <= 0, ball_x = 0 and dx = +SPEED. If nx >= H_ACTIVE-BALL_SIZE (632), ball_x = 632 and dx = -SPEED. Otherwise ball_x = nx.
  - Y axis: if ny <= 0, ball_y = 0 and dy = +SPEED.
  - Paddle hit: applies when dy > 0, ny >= PADDLE_Y-BALL_SIZE (452), ny < PADDLE_Y, and there is horizontal overlap (new ball_x + BALL_SIZE > paddle_x and new ball_x < paddle_x + PADDLE_W). Then ball_y = 452, dy = -SPEED, score += 1.
  - Miss: if ny >= V_ACTIVE-BALL_SIZE (472), ball_y = 472 and state -> MISS.
  - Otherwise ball_y = ny.
  - X and Y bounces can both occur on the same tick (corner).
  - serve in PLAY is ignored.
- Simultaneous events:
  - rotary_event and frame_tick in the same cycle: the collision test uses paddle_x before the update, and the paddle still moves that cycle.
  - serve and frame_tick in IDLE: serve is taken, and the first move happens on the next tick.
- MISS lasts exactly one cycle. It decrements lives, then:
  - if the decremented lives = 0, go to OVER and the ball holds its position;
  - otherwise go to IDLE, where the ball docks on the next cycle.
  - Score is kept.
- OVER: all motion stops. serve -> IDLE with score = 0, lives = LIVES, paddle_x = 288, ball docked.
- Outputs are registered. Latency from frame_tick to the updated ball_x/ball_y is 1 cycle.

Test Plan:
1. Reset held 3 cycles then released -> paddle_x = 288, ball (316, 452), score 0, lives 3, state 0. Releasing into a concurrent serve is taken on the first cycle after release.
2. 40 rotary_event pulses with rotary_right = 1 -> paddle_x clamps at 576, ball_x = 604 in IDLE. Then 80 pulses with rotary_right = 0 -> paddle_x = 0, ball_x = 28.
3. From reset, serve, then 1 frame_tick -> ball (318, 450), state 1. After 158 ticks -> ball_x = 632, dx negative; tick 159 -> ball_x = 630. Tick 226 -> ball_y = 0, then descending.
4. Continuing scenario 3, with 36 left rotary events applied before tick 452 (paddle_x = 0) -> at tick 452 ball (44, 452), score 1, dy negative.
5. Same as scenario 4 but paddle left at 288 -> at tick 462, ball_y = 472, state MISS for one cycle, lives = 2, then IDLE with ball docked at (316, 452).
6. Three misses -> state OVER, paddle frozen, ticks ignored. serve -> IDLE, lives 3, score 0. A rotary_event coinciding with a frame_tick during PLAY confirms the collision test uses the old paddle_x.
